// File: rtl/dp_pkg.sv
// Shared encodings for the single-bus sequenced datapath: op codes, FSM states, op classes.
package dp_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned ST_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd4;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd5;
  localparam logic [OP_W-1:0] OP_SRA  = 4'd6;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd7;
  localparam logic [OP_W-1:0] OP_DIV  = 4'd8;
  localparam logic [OP_W-1:0] OP_LOAD = 4'd9;
  localparam logic [OP_W-1:0] OP_MFHI = 4'd10;
  localparam logic [OP_W-1:0] OP_MFLO = 4'd11;
  // Codes 12-15 are NOPs: they walk T1-T2-T3, drive nothing, write nothing, and still pulse done.

  localparam logic [ST_W-1:0] S_IDLE = 3'd0;
  localparam logic [ST_W-1:0] S_T1   = 3'd1;
  localparam logic [ST_W-1:0] S_T2   = 3'd2;
  localparam logic [ST_W-1:0] S_TDIV = 3'd3;
  localparam logic [ST_W-1:0] S_T3   = 3'd4;

  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    return op <= OP_MUL;
  endfunction

  // ALU ops and DIV read rs/rt through Y and write rd from ZLO.
  function automatic logic op_uses_regs(input logic [OP_W-1:0] op);
    return op <= OP_DIV;
  endfunction

  function automatic logic op_is_mf(input logic [OP_W-1:0] op);
    return (op == OP_MFHI) || (op == OP_MFLO);
  endfunction

endpackage

// File: rtl/bus_seq_datapath_if.sv
// Command, status and debug signals of the sequenced datapath.
interface bus_seq_datapath_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 16
) ();
  import dp_pkg::*;

  localparam int unsigned RW = $clog2(NREGS);

  logic             start;
  logic [OP_W-1:0]  op;
  logic [RW-1:0]    rd;
  logic [RW-1:0]    rs;
  logic [RW-1:0]    rt;
  logic [WIDTH-1:0] mdatain;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic [RW-1:0]    dbg_sel;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output start, op, rd, rs, rt, mdatain, dbg_sel,
    input  busy, done, bus_out, hi_out, lo_out, dbg_data
  );

  modport slave (
    input  start, op, rd, rs, rt, mdatain, dbg_sel,
    output busy, done, bus_out, hi_out, lo_out, dbg_data
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative signed divider: restoring division on magnitudes, one quotient bit per cycle.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_quotient_c,
  output logic [WIDTH-1:0] o_remainder_c
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_dividend;
  logic [CW-1:0]    r_cnt;
  logic             r_qneg, r_rneg, r_dz;
  logic [WIDTH-1:0] w_dd_mag, w_dv_mag;

  // One restoring step: shift the next dividend bit into the partial remainder.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    logic           qbit;
    sh = {rem, quo[WIDTH-1]};
    if (sh >= {1'b0, dvs}) begin
      sh   = sh - {1'b0, dvs};
      qbit = 1'b1;
    end else begin
      qbit = 1'b0;
    end
    return {sh[WIDTH-1:0], quo[WIDTH-2:0], qbit};
  endfunction

  assign w_dd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_dv_mag = i_divisor[WIDTH-1]  ? -i_divisor  : i_divisor;

  // The load edge performs the first step, leaving WIDTH-1 steps for the busy cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_dividend <= '0;
      r_cnt      <= '0;
      r_qneg     <= 1'b0;
      r_rneg     <= 1'b0;
      r_dz       <= 1'b0;
    end else if (i_load) begin
      {r_rem, r_quo} <= div_step('0, w_dd_mag, w_dv_mag);
      r_dvs          <= w_dv_mag;
      r_dividend     <= i_dividend;
      r_cnt          <= CW'(WIDTH - 1);
      r_qneg         <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      r_rneg         <= i_dividend[WIDTH-1];
      r_dz           <= (i_divisor == '0);
    end else if (r_cnt != '0) begin
      {r_rem, r_quo} <= div_step(r_rem, r_quo, r_dvs);
      r_cnt          <= r_cnt - CW'(1);
    end
  end

  assign o_busy        = (r_cnt != '0);
  assign o_quotient_c  = r_dz ? '1 : (r_qneg ? -r_quo : r_quo);
  assign o_remainder_c = r_dz ? r_dividend : (r_rneg ? -r_rem : r_rem);

endmodule

// File: rtl/bus_seq_datapath.sv
// Single-bus register datapath with a built-in step sequencer executing one instruction per start.
module bus_seq_datapath
  import dp_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREGS   = 16,
  parameter bit          R0_ZERO = 1'b0
) (
  input logic                clock,
  input logic                clear,
  bus_seq_datapath_if.slave  io
);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned SW = $clog2(WIDTH);

  logic [ST_W-1:0]    r_state, w_state_next;
  logic [OP_W-1:0]    r_op;
  logic [RW-1:0]      r_rd, r_rs, r_rt;
  logic [WIDTH-1:0]   r_regs [NREGS];
  logic [WIDTH-1:0]   r_y, r_mdr, r_hi, r_lo;
  logic [2*WIDTH-1:0] r_z;
  logic               r_done, w_done_next;
  logic [WIDTH-1:0]   w_bus, w_alu_lo, w_alu_hi, w_quo, w_rem;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_reg_we, w_div_load, w_div_busy;

  function automatic logic [WIDTH-1:0] rreg(input logic [RW-1:0] idx);
    if (R0_ZERO && (idx == '0)) return '0;
    return r_regs[idx];
  endfunction

  // State register
  always_ff @(posedge clock or posedge clear) begin
    if (clear) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and completion pulse
  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: if (io.start) w_state_next = S_T1;
      S_T1: begin
        if (op_is_mf(r_op)) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end else if (r_op == OP_LOAD) begin
          w_state_next = S_T3;
        end else begin
          w_state_next = S_T2;
        end
      end
      S_T2:   w_state_next = (r_op == OP_DIV) ? S_TDIV : S_T3;
      S_TDIV: if (!w_div_busy) w_state_next = S_T3;
      S_T3: begin
        w_state_next = S_IDLE;
        w_done_next  = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus driver select: at most one source per state
  always_comb begin
    w_bus = '0;
    case (r_state)
      S_T1: begin
        if (r_op == OP_MFHI)         w_bus = r_hi;
        else if (r_op == OP_MFLO)    w_bus = r_lo;
        else if (op_uses_regs(r_op)) w_bus = rreg(r_rs);
      end
      S_T2: if (op_uses_regs(r_op)) w_bus = rreg(r_rt);
      S_T3: begin
        if (r_op == OP_LOAD)         w_bus = r_mdr;
        else if (op_uses_regs(r_op)) w_bus = r_z[WIDTH-1:0];
      end
      default: w_bus = '0;
    endcase
  end

  assign w_prod = {{WIDTH{r_y[WIDTH-1]}}, r_y} * {{WIDTH{w_bus[WIDTH-1]}}, w_bus};

  always_comb begin
    w_alu_hi = '0;
    w_alu_lo = '0;
    case (r_op)
      OP_ADD:  w_alu_lo = r_y + w_bus;
      OP_SUB:  w_alu_lo = r_y - w_bus;
      OP_AND:  w_alu_lo = r_y & w_bus;
      OP_OR:   w_alu_lo = r_y | w_bus;
      OP_SHL:  w_alu_lo = r_y << w_bus[SW-1:0];
      OP_SHR:  w_alu_lo = r_y >> w_bus[SW-1:0];
      OP_SRA:  w_alu_lo = $signed(r_y) >>> w_bus[SW-1:0];
      OP_MUL:  {w_alu_hi, w_alu_lo} = w_prod;
      default: w_alu_lo = '0;
    endcase
  end

  assign w_div_load = (r_state == S_T2) && (r_op == OP_DIV);
  assign w_reg_we   = (((r_state == S_T1) && op_is_mf(r_op)) ||
                       ((r_state == S_T3) && (op_uses_regs(r_op) || (r_op == OP_LOAD)))) &&
                      !(R0_ZERO && (r_rd == '0));

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk           (clock),
    .rst           (clear),
    .i_load        (w_div_load),
    .i_dividend    (r_y),
    .i_divisor     (w_bus),
    .o_busy        (w_div_busy),
    .o_quotient_c  (w_quo),
    .o_remainder_c (w_rem)
  );

  // Datapath registers; operands land in Y/Z before write-back so rd may alias rs/rt
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_regs <= '{default: '0};
      r_y    <= '0;
      r_mdr  <= '0;
      r_z    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_op   <= '0;
      r_rd   <= '0;
      r_rs   <= '0;
      r_rt   <= '0;
    end else begin
      r_done <= w_done_next;
      if ((r_state == S_IDLE) && io.start) begin
        r_op <= io.op;
        r_rd <= io.rd;
        r_rs <= io.rs;
        r_rt <= io.rt;
      end
      if (w_reg_we) r_regs[r_rd] <= w_bus;
      case (r_state)
        S_T1: begin
          if (r_op == OP_LOAD)         r_mdr <= io.mdatain;
          else if (op_uses_regs(r_op)) r_y   <= w_bus;
        end
        S_T2:   if (op_is_alu(r_op)) r_z <= {w_alu_hi, w_alu_lo};
        S_TDIV: if (!w_div_busy)     r_z <= {w_rem, w_quo};
        S_T3: begin
          if ((r_op == OP_MUL) || (r_op == OP_DIV)) begin
            r_hi <= r_z[2*WIDTH-1:WIDTH];
            r_lo <= r_z[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign io.busy     = (r_state != S_IDLE);
  assign io.done     = r_done;
  assign io.bus_out  = w_bus;
  assign io.hi_out   = r_hi;
  assign io.lo_out   = r_lo;
  assign io.dbg_data = rreg(io.dbg_sel);

endmodule

// File: tb/tb_bus_seq_datapath.sv
// Directed plus randomized bench for bus_seq_datapath against an arithmetic reference model.
module tb_bus_seq_datapath;
  import dp_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 16;
  localparam int unsigned RW = 4;

  logic clk;
  logic clear;
  int   tests = 0;
  int   fails = 0;

  logic [W-1:0] m_regs [N];
  logic [W-1:0] m_hi, m_lo;

  bus_seq_datapath_if #(.WIDTH(W), .NREGS(N)) io ();

  bus_seq_datapath #(.WIDTH(W), .NREGS(N), .R0_ZERO(1'b1)) dut (
    .clock (clk),
    .clear (clear),
    .io    (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mread(input int i);
    return (i == 0) ? '0 : m_regs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < N; i++) begin
      io.dbg_sel = RW'(i);
      #1;
      check(tag, io.dbg_data, mread(i));
    end
  endtask

  // Run one command; the model decides result, latency and the bus value in the last busy cycle.
  task automatic do_cmd(input logic [3:0] op, input int rd, input int rs, input int rt,
                        input logic [W-1:0] md, input bit inject);
    logic [W-1:0] a, b, res, last;
    longint       p, q, r;
    int           lat, n;
    bit           wr;
    a = mread(rs); b = mread(rt); res = '0; wr = 1'b1; lat = 3;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_SHL:  res = a << b[4:0];
      OP_SHR:  res = a >> b[4:0];
      OP_SRA:  res = $signed(a) >>> b[4:0];
      OP_MUL: begin
        p = longint'($signed(a)) * longint'($signed(b));
        res = p[31:0]; m_hi = p[63:32]; m_lo = p[31:0];
      end
      OP_DIV: begin
        lat = W + 3;
        if (b == '0) begin
          res = '1; m_hi = a;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          res = q[31:0]; m_hi = r[31:0];
        end
        m_lo = res;
      end
      OP_LOAD: begin lat = 2; res = md; end
      OP_MFHI: begin lat = 1; res = m_hi; end
      OP_MFLO: begin lat = 1; res = m_lo; end
      default: wr = 1'b0;
    endcase
    if (wr && rd != 0) m_regs[rd] = res;

    @(negedge clk);
    io.start = 1'b1; io.op = op; io.rd = RW'(rd); io.rs = RW'(rs); io.rt = RW'(rt); io.mdatain = md;
    @(posedge clk); #1;
    io.start = 1'b0;
    check("busy_after_accept", W'(io.busy), W'(1));
    check("done_low_after_accept", W'(io.done), '0);
    n = 0; last = '0;
    while (n < 100) begin
      last = io.bus_out;
      @(posedge clk); #1;
      n++;
      if (io.done) break;
      io.start = (inject && n == 5);
      if (inject && n == 5) io.op = OP_ADD;
    end
    io.start = 1'b0;
    check($sformatf("latency_op%0d", op), W'(n), W'(lat));
    check($sformatf("bus_last_op%0d", op), last, wr ? res : '0);
    check("busy_end", W'(io.busy), '0);
    check("bus_idle", io.bus_out, '0);
    io.dbg_sel = RW'(rd);
    #1;
    check($sformatf("rd_op%0d", op), io.dbg_data, mread(rd));
    check("hi", io.hi_out, m_hi);
    check("lo", io.lo_out, m_lo);
    if (inject) begin
      repeat (3) begin
        @(posedge clk); #1;
        check("no_queued_busy", W'(io.busy), '0);
        check("no_second_done", W'(io.done), '0);
      end
    end
  endtask

  initial begin
    clear = 1'b1;
    io.start = 1'b0; io.op = '0; io.rd = '0; io.rs = '0; io.rt = '0;
    io.mdatain = '0; io.dbg_sel = '0;
    model_reset();
    #12;
    check("rst_busy", W'(io.busy), '0);
    check("rst_done", W'(io.done), '0);
    check("rst_bus", io.bus_out, '0);
    check("rst_hi", io.hi_out, '0);
    check("rst_lo", io.lo_out, '0);
    sweep("rst_reg");
    @(negedge clk);
    clear = 1'b0;

    do_cmd(OP_LOAD, 1, 0, 0, 32'h0000_0007, 1'b0);
    do_cmd(OP_LOAD, 2, 0, 0, 32'hFFFF_FFFD, 1'b0);
    do_cmd(OP_ADD,  3, 1, 2, '0, 1'b0);
    check("add_r3_const", mread(3), 32'h0000_0004);
    do_cmd(OP_MUL,  4, 2, 1, '0, 1'b0);
    check("mul_hi_const", io.hi_out, 32'hFFFF_FFFF);
    check("mul_lo_const", io.lo_out, 32'hFFFF_FFEB);

    // Asynchronous clear in the middle of a divide
    @(negedge clk);
    io.start = 1'b1; io.op = OP_DIV; io.rd = 4'd5; io.rs = 4'd2; io.rt = 4'd1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (6) @(posedge clk);
    #3 clear = 1'b1;
    #1;
    model_reset();
    check("mid_rst_busy", W'(io.busy), '0);
    check("mid_rst_done", W'(io.done), '0);
    check("mid_rst_hi", io.hi_out, '0);
    check("mid_rst_lo", io.lo_out, '0);
    sweep("mid_rst_reg");
    @(negedge clk);
    clear = 1'b0;
    check("post_rst_idle", W'(io.busy), '0);

    do_cmd(OP_LOAD, 1, 0, 0, 32'h0000_0007, 1'b0);
    do_cmd(OP_LOAD, 2, 0, 0, 32'hFFFF_FFEC, 1'b0);
    do_cmd(OP_DIV,  5, 2, 1, '0, 1'b0);
    check("div_lo_const", io.lo_out, 32'hFFFF_FFFE);
    check("div_hi_const", io.hi_out, 32'hFFFF_FFFA);
    do_cmd(OP_LOAD, 7, 0, 0, 32'h0000_0014, 1'b0);
    do_cmd(OP_DIV,  8, 7, 0, '0, 1'b1);
    check("div0_lo_const", io.lo_out, 32'hFFFF_FFFF);
    check("div0_hi_const", io.hi_out, 32'h0000_0014);
    do_cmd(OP_LOAD, 1, 0, 0, 32'h0000_0024, 1'b0);
    do_cmd(OP_SRA,  6, 2, 1, '0, 1'b0);
    check("sra_r6_const", mread(6), 32'hFFFF_FFFE);
    do_cmd(4'd14,   9, 1, 2, '0, 1'b0);
    sweep("nop_reg");
    do_cmd(OP_MFHI, 10, 0, 0, '0, 1'b0);
    do_cmd(OP_MFLO, 11, 0, 0, '0, 1'b0);
    do_cmd(OP_LOAD, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    do_cmd(OP_ADD,  3, 3, 3, '0, 1'b0);
    do_cmd(OP_SUB,  12, 0, 2, '0, 1'b0);

    for (int k = 0; k < 60; k++) begin
      do_cmd(4'($urandom_range(0, 15)), int'($urandom_range(0, N - 1)),
             int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)),
             W'($urandom), 1'b0);
    end
    sweep("final_reg");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
